tonegen_poly: RTL

//  Polyphonic successor to the single-voice MIDI tone generator. Holds C_VOICES independent voices, each with a MIDI note, gate and ADSR-lite envelope.

---
 rtl/tonegen_poly.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/tonegen_poly.sv
// Polyphonic tone generator: C_VOICES time-multiplexed voices with ADSR-lite envelopes, mixed and saturated to signed PCM.
// Latency: pcm_out/pcm_valid update C_VOICES+2 cycles after each sample tick; busy covers the voice sweep.
// Backpressure: none; the output is a held sample with a 1-cycle strobe and the consumer must keep up.
module tonegen_poly #(
    parameter int C_VOICES     = 4,
    parameter int C_PCM_BITS   = 16,
    parameter int C_PHASE_BITS = 24,
    parameter int C_ENV_BITS   = 8,
    parameter int C_ENV_STEP   = 1,
    parameter int C_CLK_HZ     = 25000000,
    parameter int C_SAMPLE_DIV = 512,
    parameter int C_MIX_SHIFT  = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [C_VOICES*7-1:0]        note_in,
    input  logic [C_VOICES-1:0]          gate_in,
    input  logic [1:0]                   wave_sel,
    output logic signed [C_PCM_BITS-1:0] pcm_out,
    output logic                         pcm_valid,
    output logic                         busy
);
    localparam int PW = C_PCM_BITS;
    localparam int EB = C_ENV_BITS;
    localparam int CW = $clog2(C_SAMPLE_DIV);
    localparam int SW = $clog2(C_VOICES + 1);
    localparam int VW = (C_VOICES > 1) ? $clog2(C_VOICES) : 1;
    localparam int AW = PW + $clog2(C_VOICES) + 1;

    localparam logic signed [PW-1:0] M_PCM    = PW'((1 << (PW - 1)) - 1);
    localparam logic signed [PW:0]   M_EXT    = (PW + 1)'((1 << (PW - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_HI   = AW'((1 << (PW - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_LO   = ~SAT_HI;
    localparam logic [EB-1:0]        ENV_MAX  = '1;
    localparam logic [EB-1:0]        ENV_STEP = EB'(C_ENV_STEP);
    localparam logic [EB-1:0]        ENV_HI   = ENV_MAX - ENV_STEP;

    typedef enum logic [1:0] {ST_IDLE, ST_ATTACK, ST_SUSTAIN, ST_RELEASE} env_st_t;

    function automatic int inc_calc(input int n);
        real f;
        real x;
        f = 440.0 * (2.0 ** ((n - 69) / 12.0));
        x = f * (2.0 ** C_PHASE_BITS) * C_SAMPLE_DIV / C_CLK_HZ;
        return $rtoi(x + 0.5);
    endfunction

    logic [C_PHASE_BITS-1:0] inc_rom [128];
    for (genvar n = 0; n < 128; n++) begin : g_rom
        localparam logic [C_PHASE_BITS-1:0] INC = C_PHASE_BITS'(inc_calc(n));
        assign inc_rom[n] = INC;
    end

    logic [CW-1:0]           cnt;
    logic [SW-1:0]           slot;
    logic signed [AW-1:0]    acc;
    logic [C_PHASE_BITS-1:0] phase [C_VOICES];
    logic [EB-1:0]           env   [C_VOICES];
    env_st_t                 st    [C_VOICES];

    logic                    tick;
    logic [VW-1:0]           vidx;
    logic [6:0]              cur_note;
    logic                    cur_gate;
    logic [C_PHASE_BITS-1:0] cur_ph;
    logic [EB-1:0]           cur_env;
    env_st_t                 cur_st;

    assign tick     = (cnt == CW'(C_SAMPLE_DIV - 1));
    assign vidx     = slot[VW-1:0];
    assign cur_note = note_in[7*int'(vidx) +: 7];
    assign cur_gate = gate_in[vidx];
    assign cur_ph   = phase[vidx];
    assign cur_env  = env[vidx];
    assign cur_st   = st[vidx];

    // Contribution is taken from the voice's stored state before this slot updates it.
    logic [PW-1:0]          p_top;
    logic [PW-2:0]          tri_t;
    logic signed [PW:0]     tri_w;
    logic signed [PW-1:0]   wave;
    logic signed [PW+EB:0]  prod;
    logic signed [PW-1:0]   contrib;
    logic signed [AW-1:0]   acc_nxt;
    logic signed [AW-1:0]   acc_sh;
    logic signed [PW-1:0]   sat_val;

    assign p_top   = cur_ph[C_PHASE_BITS-1 -: PW];
    assign tri_t   = p_top[PW-1] ? ~p_top[PW-2:0] : p_top[PW-2:0];
    assign tri_w   = $signed({1'b0, tri_t, 1'b0}) - M_EXT;
    assign prod    = wave * $signed({1'b0, cur_env});
    assign contrib = PW'(prod >>> EB);
    assign acc_nxt = acc + {{(AW-PW){contrib[PW-1]}}, contrib};
    assign acc_sh  = acc >>> C_MIX_SHIFT;

    always_comb begin
        wave = '0;
        case (wave_sel)
            2'd0:    wave = p_top[PW-1] ? -M_PCM : M_PCM;
            2'd1:    wave = $signed({~p_top[PW-1], p_top[PW-2:0]});
            2'd2:    wave = PW'(tri_w);
            default: wave = '0;
        endcase
        if (cur_st == ST_IDLE) begin
            wave = '0;
        end
    end

    always_comb begin
        sat_val = acc_sh[PW-1:0];
        if (acc_sh > SAT_HI) begin
            sat_val = M_PCM;
        end else if (acc_sh < SAT_LO) begin
            sat_val = ~M_PCM;
        end
    end

    env_st_t                 nst;
    logic [EB-1:0]           nenv;
    logic [C_PHASE_BITS-1:0] nph;

    always_comb begin
        nst  = cur_st;
        nenv = cur_env;
        nph  = cur_ph + inc_rom[cur_note];
        case (cur_st)
            ST_IDLE: begin
                nph = cur_ph;
                if (cur_gate) begin
                    nst = ST_ATTACK;
                    nph = '0;
                end
            end
            ST_ATTACK: begin
                if (!cur_gate) begin
                    nst = ST_RELEASE;
                end else if (cur_env >= ENV_HI) begin
                    nenv = ENV_MAX;
                    nst  = ST_SUSTAIN;
                end else begin
                    nenv = cur_env + ENV_STEP;
                end
            end
            ST_SUSTAIN: begin
                if (!cur_gate) begin
                    nst = ST_RELEASE;
                end
            end
            default: begin
                if (cur_gate) begin
                    nst = ST_ATTACK;
                end else if (cur_env <= ENV_STEP) begin
                    nenv = '0;
                    nst  = ST_IDLE;
                end else begin
                    nenv = cur_env - ENV_STEP;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            slot      <= '0;
            busy      <= 1'b0;
            acc       <= '0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
            for (int v = 0; v < C_VOICES; v++) begin
                phase[v] <= '0;
                env[v]   <= '0;
                st[v]    <= ST_IDLE;
            end
        end else begin
            pcm_valid <= 1'b0;
            cnt       <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                busy <= 1'b1;
                slot <= '0;
                acc  <= '0;
            end else if (busy) begin
                if (slot == SW'(C_VOICES)) begin
                    pcm_out   <= sat_val;
                    pcm_valid <= 1'b1;
                    busy      <= 1'b0;
                end else begin
                    phase[vidx] <= nph;
                    env[vidx]   <= nenv;
                    st[vidx]    <= nst;
                    acc         <= acc_nxt;
                    slot        <= slot + 1'b1;
                end
            end
        end
    end
endmodule
